mic1_run_ctrl: RTL

- Run-control sequencer for the MIC-1 microarchitecture on the FPGA board.
- Takes debounced button levels (outputs of the per-button debouncers) and produces:
  - the datapath clock-enable,
  - a synchronous datapath reset pulse,
  - an enabled-cycle counter,
  - status LEDs.
- Sits between the debouncers and the MIC-1 core; it is the only block that gates core execution.

---
 rtl/mic1_ctrl_pkg.sv | 31 +++
 rtl/btn_rise_detect.sv | 27 ++
 rtl/mic1_run_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mic1_ctrl_pkg.sv
// Shared types and index constants for the MIC-1 run-control block.
package mic1_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_SEQ = 3'd0,
    IDLE      = 3'd1,
    RUN       = 3'd2,
    STEP      = 3'd3,
    HALTED    = 3'd4
  } ctrl_state_t;

  localparam int LED_RUN    = 0;
  localparam int LED_IDLE   = 1;
  localparam int LED_STEP   = 2;
  localparam int LED_HALTED = 3;
  localparam int LED_RESET  = 4;
  localparam int LED_BP     = 5;

  localparam int BTN_UP     = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_CENTER = 4;

  // Bit positions inside the edge-detector vector
  localparam int PB_RUN   = 0;
  localparam int PB_STEP  = 1;
  localparam int PB_STOP  = 2;
  localparam int PB_RESET = 3;

endpackage

// File: rtl/btn_rise_detect.sv
// Registered rising-edge detector; previous-value registers reset to ones so a
// level held through reset yields no pulse.
module btn_rise_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] lvl_i,
  output logic [N-1:0] pls_o
);

  logic [N-1:0] prev_q;
  logic [N-1:0] pls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '1;
      pls_q  <= '0;
    end else begin
      prev_q <= lvl_i;
      pls_q  <= lvl_i & ~prev_q;
    end
  end

  assign pls_o = pls_q;

endmodule

// File: rtl/mic1_run_ctrl.sv
// Run-control sequencer gating the MIC-1 datapath (enable, core reset, cycle count, LEDs).
// Optional breakpoint unit enabled by defining MIC1_BREAKPOINT_EN.
module mic1_run_ctrl
  import mic1_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES   = 1,
  parameter int RST_PULSE_LEN = 4,
  parameter int MPC_W         = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_stop,
  input  logic             btn_reset,
  input  logic             halt_req,
  input  logic [MPC_W-1:0] mpc,
`ifdef MIC1_BREAKPOINT_EN
  input  logic [MPC_W-1:0] bp_addr,
  input  logic             bp_valid,
`endif
  output logic             cpu_en,
  output logic             cpu_rst_n,
  output logic [31:0]      cyc_cnt,
  output logic [2:0]       state,
  output logic [5:0]       led
);

  localparam logic [7:0] RST_LOAD  = 8'(RST_PULSE_LEN);
  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);

  logic [3:0]  btn_lvl, btn_pls;
  logic        p_run, p_step, p_stop, p_reset;
  ctrl_state_t state_q, state_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [7:0]  scnt_q, scnt_d;
  logic [31:0] cyc_q, cyc_d;
  logic        bp_match;
  logic        bp_led;
  logic        halt;

  assign btn_lvl = {btn_reset, btn_stop, btn_step, btn_run};

  btn_rise_detect #(.N(4)) u_rise (
    .clk   (clk),
    .rst_n (resetn),
    .lvl_i (btn_lvl),
    .pls_o (btn_pls)
  );

  assign p_run   = btn_pls[PB_RUN];
  assign p_step  = btn_pls[PB_STEP];
  assign p_stop  = btn_pls[PB_STOP];
  assign p_reset = btn_pls[PB_RESET];

`ifdef MIC1_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic skip_q, skip_d;

  // skip lets a resume from a breakpoint execute the breakpointed address once
  assign bp_match = (state_q == RUN) && bp_valid && (mpc == bp_addr) && !skip_q;

  always_comb begin
    skip_d = skip_q;
    if (state_d == RUN && state_q != RUN) skip_d = 1'b1;
    else if (state_q == RUN)              skip_d = 1'b0;

    bp_hit_d = bp_hit_q;
    if (state_d == RESET_SEQ)  bp_hit_d = 1'b0;
    else if (bp_match)         bp_hit_d = 1'b1;
    else if (p_run || p_step)  bp_hit_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_led = bp_hit_q;
`else
  logic unused_mpc;
  assign unused_mpc = ^mpc;
  assign bp_match   = 1'b0;
  assign bp_led     = 1'b0;
`endif

  assign cpu_en    = ((state_q == RUN) || (state_q == STEP)) && !bp_match;
  assign cpu_rst_n = (state_q != RESET_SEQ);
  assign halt      = halt_req && cpu_en;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    scnt_d  = scnt_q;
    if (p_reset) begin
      state_d = RESET_SEQ;
      rcnt_d  = RST_LOAD;
    end else begin
      case (state_q)
        RESET_SEQ: begin
          if (rcnt_q <= 8'd1) state_d = IDLE;
          else                rcnt_d  = rcnt_q - 8'd1;
        end
        IDLE: begin
          if (!p_stop) begin
            if (p_step) begin
              state_d = STEP;
              scnt_d  = STEP_LOAD;
            end else if (p_run) begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (halt)                     state_d = HALTED;
          else if (bp_match || p_stop)  state_d = IDLE;
        end
        STEP: begin
          if (halt)                             state_d = HALTED;
          else if (p_stop || scnt_q <= 8'd1)    state_d = IDLE;
          else                                  scnt_d  = scnt_q - 8'd1;
        end
        HALTED: state_d = HALTED;
        default: begin
          state_d = RESET_SEQ;
          rcnt_d  = RST_LOAD;
        end
      endcase
    end
  end

  // Counter is held at zero for the whole reset sequence and saturates at all-ones
  always_comb begin
    cyc_d = cyc_q;
    if (state_d == RESET_SEQ)          cyc_d = '0;
    else if (cpu_en && cyc_q != '1)    cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RESET_SEQ;
      rcnt_q  <= RST_LOAD;
      scnt_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      scnt_q  <= scnt_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    led             = '0;
    led[LED_RUN]    = (state_q == RUN);
    led[LED_IDLE]   = (state_q == IDLE);
    led[LED_STEP]   = (state_q == STEP);
    led[LED_HALTED] = (state_q == HALTED);
    led[LED_RESET]  = (state_q == RESET_SEQ);
    led[LED_BP]     = bp_led;
  end

  assign cyc_cnt = cyc_q;
  assign state   = state_q;

endmodule
